// File: rtl/next_pc_unit.sv
// Next-PC sequencer: resolves ID-stage redirects, owns the PC, squashes IF/ID, sticky HALT.
// Optional performance counters are built when NPC_PERF_EN is defined.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] KTEXT_PC = 32'h8000_0180
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIDValid,
  input  logic        iStall,
  input  logic [2:0]  iOrigPC,
  input  logic        iJump,
  input  logic        iBranch,
  input  logic        inBranch,
  input  logic        iJr,
  input  logic [31:0] iRsData,
  input  logic [31:0] iRtData,
  input  logic [15:0] iImm16,
  input  logic [25:0] iJTarget,
  input  logic [31:0] iPCPlus4ID,
  output logic [31:0] oPC,
  output logic [31:0] oPCPlus4,
  output logic        oFlushIF,
  output logic        oHalted,
  output logic [1:0]  oHaltCause
`ifdef NPC_PERF_EN
  ,
  output logic [31:0] oTakenCnt,
  output logic [31:0] oRedirCnt,
  output logic [31:0] oStallCnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cause_q, cause_d;
  logic        flush;
  logic        br_fire, redir_fire;

  logic [31:0] br_tgt, j_tgt, redir_tgt;
  logic        is_illegal, jr_misalign, br_taken, redir_any;
  logic        unused_jump;

  // iJump carries no information beyond iOrigPC: a jump without 010/100 falls through.
  assign unused_jump = iJump;

  assign br_tgt      = iPCPlus4ID + {{14{iImm16[15]}}, iImm16, 2'b00};
  assign j_tgt       = {iPCPlus4ID[31:28], iJTarget, 2'b00};
  assign is_illegal  = (iOrigPC == 3'b011) || (iOrigPC == 3'b110) || (iOrigPC == 3'b111);
  assign jr_misalign = (iOrigPC == 3'b010) && iJr && (iRsData[1:0] != 2'b00);
  assign br_taken    = ((iOrigPC == 3'b001) && iBranch  && (iRsData == iRtData)) ||
                       ((iOrigPC == 3'b101) && inBranch && (iRsData != iRtData));
  assign redir_any   = br_taken || (iOrigPC == 3'b010) || (iOrigPC == 3'b100);

  always_comb begin
    redir_tgt = br_tgt;
    if (iOrigPC == 3'b010) redir_tgt = iJr ? iRsData : j_tgt;
    else if (iOrigPC == 3'b100) redir_tgt = KTEXT_PC;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    flush      = 1'b0;
    br_fire    = 1'b0;
    redir_fire = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!iStall) begin
          if (iIDValid && is_illegal) begin
            state_d = ST_HALT;
            cause_d = 2'b01;
            flush   = 1'b1;
          end else if (iIDValid && jr_misalign) begin
            state_d = ST_HALT;
            cause_d = 2'b10;
            flush   = 1'b1;
          end else if (iIDValid && redir_any) begin
            state_d    = ST_FLUSH;
            pc_d       = redir_tgt;
            flush      = 1'b1;
            br_fire    = br_taken;
            redir_fire = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_FLUSH: begin
        if (!iStall) begin
          state_d = ST_RUN;
          pc_d    = pc_q + 32'd4;
        end
      end
      ST_HALT: flush = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  assign oPC        = pc_q;
  assign oPCPlus4   = pc_q + 32'd4;
  assign oFlushIF   = flush && !iRST;
  assign oHalted    = (state_q == ST_HALT);
  assign oHaltCause = cause_q;

`ifdef NPC_PERF_EN
  logic [31:0] taken_q, redir_q, stall_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      taken_q <= '0;
      redir_q <= '0;
      stall_q <= '0;
    end else begin
      if (br_fire && (taken_q != '1)) taken_q <= taken_q + 32'd1;
      if (redir_fire && (redir_q != '1)) redir_q <= redir_q + 32'd1;
      if ((state_q == ST_RUN) && iStall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign oTakenCnt = taken_q;
  assign oRedirCnt = redir_q;
  assign oStallCnt = stall_q;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: directed cases then randomized traffic against a rule-level model.
module tb_next_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] KTEXT_PC = 32'h8000_0180;

  logic        iCLK, iRST, iIDValid, iStall, iJump, iBranch, inBranch, iJr;
  logic [2:0]  iOrigPC;
  logic [31:0] iRsData, iRtData, iPCPlus4ID;
  logic [15:0] iImm16;
  logic [25:0] iJTarget;
  logic [31:0] oPC, oPCPlus4;
  logic        oFlushIF, oHalted;
  logic [1:0]  oHaltCause;
`ifdef NPC_PERF_EN
  logic [31:0] oTakenCnt, oRedirCnt, oStallCnt;
`endif

  next_pc_unit #(.RESET_PC(RESET_PC), .KTEXT_PC(KTEXT_PC)) dut (
    .iCLK(iCLK), .iRST(iRST), .iIDValid(iIDValid), .iStall(iStall),
    .iOrigPC(iOrigPC), .iJump(iJump), .iBranch(iBranch), .inBranch(inBranch),
    .iJr(iJr), .iRsData(iRsData), .iRtData(iRtData), .iImm16(iImm16),
    .iJTarget(iJTarget), .iPCPlus4ID(iPCPlus4ID),
    .oPC(oPC), .oPCPlus4(oPCPlus4), .oFlushIF(oFlushIF), .oHalted(oHalted),
    .oHaltCause(oHaltCause)
`ifdef NPC_PERF_EN
    , .oTakenCnt(oTakenCnt), .oRedirCnt(oRedirCnt), .oStallCnt(oStallCnt)
`endif
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  typedef struct {
    logic        rst, valid, stall, jump, br, nbr, jr;
    logic [2:0]  orig;
    logic [31:0] rs, rt, pc4;
    logic [15:0] imm;
    logic [25:0] jt;
  } stim_t;

  typedef struct {
    bit          care;
    logic [31:0] pc;
    logic        flush, halted;
    logic [1:0]  cause;
    logic [31:0] tcnt, rcnt, scnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: mode 0 = running, 1 = one-cycle squash pending, 2 = halted.
  bit          m_known = 0;
  int          m_mode  = 0;
  logic [31:0] m_pc    = '0;
  logic [1:0]  m_cause = '0;
  logic [31:0] m_tcnt = '0, m_rcnt = '0, m_scnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flush", {31'd0, oFlushIF}, {31'd0, e.flush});
        if (e.care) begin
          check("pc", oPC, e.pc);
          check("pcplus4", oPCPlus4, e.pc + 32'd4);
          check("halted", {31'd0, oHalted}, {31'd0, e.halted});
          check("cause", {30'd0, oHaltCause}, {30'd0, e.cause});
`ifdef NPC_PERF_EN
          check("taken_cnt", oTakenCnt, e.tcnt);
          check("redir_cnt", oRedirCnt, e.rcnt);
          check("stall_cnt", oStallCnt, e.scnt);
`endif
        end
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply one cycle of inputs, predict this cycle's outputs, then advance the model across the edge.
  task automatic step(input stim_t s);
    exp_t        e;
    int          n_mode;
    logic [31:0] n_pc, tgt;
    logic [1:0]  n_cause;
    bit          taken, is_br;
    iRST = s.rst; iIDValid = s.valid; iStall = s.stall; iOrigPC = s.orig;
    iJump = s.jump; iBranch = s.br; inBranch = s.nbr; iJr = s.jr;
    iRsData = s.rs; iRtData = s.rt; iImm16 = s.imm; iJTarget = s.jt; iPCPlus4ID = s.pc4;

    e.care = m_known; e.pc = m_pc; e.halted = (m_mode == 2); e.cause = m_cause;
    e.tcnt = m_tcnt; e.rcnt = m_rcnt; e.scnt = m_scnt; e.flush = 1'b0;
    n_mode = m_mode; n_pc = m_pc; n_cause = m_cause;

    if (s.rst) begin
      n_mode = 0; n_pc = RESET_PC; n_cause = 2'b00;
      m_tcnt = '0; m_rcnt = '0; m_scnt = '0;
    end else if (m_mode == 2) begin
      e.flush = 1'b1;
    end else if (m_mode == 1) begin
      if (!s.stall) begin n_mode = 0; n_pc = m_pc + 32'd4; end
    end else if (s.stall) begin
      m_scnt = sat_inc(m_scnt);
    end else if (!s.valid) begin
      n_pc = m_pc + 32'd4;
    end else if (s.orig == 3'd3 || s.orig == 3'd6 || s.orig == 3'd7) begin
      n_mode = 2; n_cause = 2'b01; e.flush = 1'b1;
    end else if (s.orig == 3'd2 && s.jr && (s.rs % 4 != 0)) begin
      n_mode = 2; n_cause = 2'b10; e.flush = 1'b1;
    end else begin
      taken = 0; is_br = 0; tgt = '0;
      if (s.orig == 3'd1 && s.br && s.rs == s.rt) begin
        taken = 1; is_br = 1; tgt = s.pc4 + 32'(4 * $signed(s.imm));
      end else if (s.orig == 3'd5 && s.nbr && s.rs != s.rt) begin
        taken = 1; is_br = 1; tgt = s.pc4 + 32'(4 * $signed(s.imm));
      end else if (s.orig == 3'd2) begin
        taken = 1;
        tgt = s.jr ? s.rs : ((s.pc4 & 32'hF000_0000) | (32'(s.jt) * 4));
      end else if (s.orig == 3'd4) begin
        taken = 1; tgt = KTEXT_PC;
      end
      if (taken) begin
        n_mode = 1; n_pc = tgt; e.flush = 1'b1;
        m_rcnt = sat_inc(m_rcnt);
        if (is_br) m_tcnt = sat_inc(m_tcnt);
      end else begin
        n_pc = m_pc + 32'd4;
      end
    end
    exp_q.push_back(e);
    @(posedge iCLK);
    #1;
    if (s.rst) m_known = 1;
    m_mode = n_mode; m_pc = n_pc; m_cause = n_cause;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.valid = 0; s.stall = 0; s.jump = 0; s.br = 0; s.nbr = 0; s.jr = 0;
    s.orig = 3'd0; s.rs = '0; s.rt = '0; s.pc4 = '0; s.imm = '0; s.jt = '0;
    return s;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    int    halt_cycles;
    s = idle();
    iRST = 1'b1; iIDValid = 0; iStall = 0; iOrigPC = '0; iJump = 0; iBranch = 0;
    inBranch = 0; iJr = 0; iRsData = '0; iRtData = '0; iImm16 = '0; iJTarget = '0; iPCPlus4ID = '0;
    @(posedge iCLK); #1;

    // Reset then free-running fetch
    s = idle(); s.rst = 1; step(s);
    repeat (3) step(idle());

    // beq taken, then beq with unequal operands
    s = idle(); s.valid = 1; s.orig = 3'd1; s.br = 1; s.rs = 5; s.rt = 5;
    s.pc4 = 32'h0040_0008; s.imm = 16'hFFFE; step(s);
    step(idle()); step(idle());
    s.rs = 6; step(s); step(idle());

    // bne wrapping past 2^32
    s = idle(); s.valid = 1; s.orig = 3'd5; s.nbr = 1; s.rs = 1; s.rt = 2;
    s.pc4 = 32'hFFFF_FFFC; s.imm = 16'h0001; step(s);
    step(idle()); step(idle());

    // j held by a two-cycle stall
    s = idle(); s.valid = 1; s.orig = 3'd2; s.jump = 1; s.jt = 26'h010_0000;
    s.pc4 = 32'h0040_0008; s.stall = 1; step(s); step(s);
    s.stall = 0; step(s); step(idle()); step(idle());

    // syscall, then misaligned jr halts
    s = idle(); s.valid = 1; s.orig = 3'd4; step(s);
    step(idle()); step(idle());
    s = idle(); s.valid = 1; s.orig = 3'd2; s.jump = 1; s.jr = 1; s.rs = 32'h0040_0002; step(s);
    s.stall = 1; step(s); step(idle()); step(idle());

    // illegal opcode, reset out of HALT
    s = idle(); s.rst = 1; step(s); step(idle());
    s = idle(); s.valid = 1; s.orig = 3'd7; step(s);
    step(idle()); step(idle());
    s = idle(); s.rst = 1; step(s); step(idle()); step(idle());

    // Randomized traffic
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      s = idle();
      r = $urandom_range(0, 99);
      s.valid = ($urandom_range(0, 9) != 0);
      s.stall = ($urandom_range(0, 5) == 0);
      if (r < 30)      s.orig = 3'd0;
      else if (r < 50) s.orig = 3'd1;
      else if (r < 70) s.orig = 3'd5;
      else if (r < 85) s.orig = 3'd2;
      else if (r < 97) s.orig = 3'd4;
      else begin
        int unsigned k = $urandom_range(0, 2);
        s.orig = (k == 0) ? 3'd3 : (k == 1) ? 3'd6 : 3'd7;
      end
      s.jump = $urandom_range(0, 1);
      s.br = ($urandom_range(0, 4) != 0);
      s.nbr = ($urandom_range(0, 4) != 0);
      s.jr = $urandom_range(0, 1);
      s.rs = $urandom();
      if ($urandom_range(0, 9) != 0) s.rs[1:0] = 2'b00;
      s.rt = $urandom_range(0, 1) ? s.rs : $urandom();
      s.pc4 = $urandom(); s.imm = 16'($urandom()); s.jt = 26'($urandom());
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
      s.rst = ($urandom_range(0, 199) == 0) || (halt_cycles > 4);
      step(s);
    end

    @(negedge iCLK); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
